// File: rtl/alu_acc_pkg.sv
// Shared types and constants for the ALU accumulator sequencer.
// Optional build macro: ALU_ACC_STICKY_FLAGS_EN (see alu_acc_flags).
package alu_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_acc_flags.sv
// Flag register: set on load, cleared on execute accept, updated on capture.
// ALU_ACC_STICKY_FLAGS_EN: carry/overflow OR-accumulate across repetitions.
module alu_acc_flags
    import alu_acc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       clear_i,
    input  logic       capture_i,
    input  logic [3:0] alu_flags_i,
    output logic [3:0] flags_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    // Next flag value from load, clear or capture
    always_comb begin
        flags_d = flags_q;
        if (load_i) begin
            flags_d = 4'b0000;
            flags_d[FLAG_N] = load_val_i[7];
            flags_d[FLAG_Z] = (load_val_i == 8'h00);
        end else if (clear_i) begin
            flags_d = 4'b0000;
        end else if (capture_i) begin
            flags_d = alu_flags_i;
`ifdef ALU_ACC_STICKY_FLAGS_EN
            flags_d[FLAG_C] = alu_flags_i[FLAG_C] | flags_q[FLAG_C];
            flags_d[FLAG_V] = alu_flags_i[FLAG_V] | flags_q[FLAG_V];
`else
            flags_d = alu_flags_i;
`endif
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= 4'b0000;
        else        flags_q <= flags_d;
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu_acc_sequencer.sv
// Command-driven initiator for an external 8-bit combinational ALU.
// Optional build macro: ALU_ACC_STICKY_FLAGS_EN (sticky carry/overflow).
module alu_acc_sequencer
    import alu_acc_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic [3:0] cmd_rep,
    output logic [7:0] alu_a,
    output logic [4:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_acc,
    output logic [3:0] rsp_flags
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] op_q, op_d;
    logic [4:0] b_q, b_d;
    logic [3:0] rep_q, rep_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fl_load, fl_clear, fl_cap;

    // Sequencing FSM: accept, drive, settle, capture, respond
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        op_d     = op_q;
        b_d      = b_q;
        rep_d    = rep_q;
        cnt_d    = cnt_q;
        fl_load  = 1'b0;
        fl_clear = 1'b0;
        fl_cap   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d   = cmd_data;
                        fl_load = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        op_d     = cmd_op;
                        b_d      = cmd_data[4:0];
                        rep_d    = cmd_rep;
                        fl_clear = 1'b1;
                        state_d  = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                cnt_d   = SETTLE_LAST;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_d  = alu_result;
                    fl_cap = 1'b1;
                    if (rep_q == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        rep_d   = rep_q - 4'd1;
                        state_d = ST_DRIVE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 8'h00;
            op_q    <= 3'b000;
            b_q     <= 5'h00;
            rep_q   <= 4'h0;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            b_q     <= b_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
        end
    end

    alu_acc_flags u_flags (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (fl_load),
        .load_val_i (cmd_data),
        .clear_i    (fl_clear),
        .capture_i  (fl_cap),
        .alu_flags_i(alu_flags),
        .flags_o    (rsp_flags)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_acc   = acc_q;
    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;

endmodule
